// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg
// Shared definitions for the round-robin register write arbiter:
//   - state_t    : FSM state encoding (IDLE / GRANT / DONE), binary
//   - clog2()    : constant function used to size requester index fields
package dff_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, never smaller than 1 so a 1-bit index is always legal.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_dff_bank.sv
// dff_bank
// W-bit storage register built from D flip-flops with a load enable and a
// synchronous active-high reset (reset value 0).
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset
//   en   in  1  load enable; q takes d on the next edge when high
//   d    in  W  data to load
//   q    out W  stored value
module dff_bank #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter
// Round-robin write arbiter in front of one shared W-bit register. Up to N
// requesters compete to load their data word; each load runs through a
// three-state sequence IDLE -> GRANT -> DONE, so at most one write lands
// every three cycles.
//
// Handshake: req[i] is a level held by requester i until it sees ack[i].
// In IDLE the arbiter picks a winner from req (round-robin, scanning upward
// from the last writer + 1) and raises gnt[winner] for one cycle. If
// req[winner] is still high during that GRANT cycle, the next edge loads
// din[winner] into q and pulses ack[winner] for one cycle; if req[winner]
// was dropped, the grant is abandoned with no write and no ack. Requests
// seen during GRANT/DONE are not lost, only deferred until IDLE.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   req        in   N    per-requester write request (level)
//   din        in   N*W  flattened data, requester i at din[i*W +: W]
//   gnt        out  N    one-hot registered grant
//   ack        out  N    one-hot registered one-cycle write-done pulse
//   q          out  W    shared register contents
//   q_src      out  IW   index of the requester that last wrote q
//   dbg_state  out  2    current FSM state (state_t encoding)
//   busy       out  1    high whenever the FSM is not in IDLE
//   q_par      out  1    even parity of q (only with DFF_ARB_PARITY_EN)
//
// Build option: define DFF_ARB_PARITY_EN to add the q_par port and its flop.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic [IW-1:0]  q_src,
  output logic [1:0]     dbg_state,
  output logic           busy
`ifdef DFF_ARB_PARITY_EN
  ,
  output logic           q_par
`endif
);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ptr;        // last requester that completed a write
  logic [IW-1:0] winner;     // requester picked in IDLE, held through GRANT
  logic [IW-1:0] pick;       // combinational round-robin choice
  logic [IW-1:0] winner_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [N-1:0]  ack_nxt;
  logic          load;       // single-cycle write strobe on GRANT -> DONE
  logic [W-1:0]  sel_d;

  // First set bit of r scanning p+1, p+2, ... modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0]  r,
                                            input logic [IW-1:0] p);
    logic [IW-1:0] res;
    logic [IW-1:0] cand;
    logic          hit;
    int            idx;
    res = '0;
    hit = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx  = (int'(p) + k) % N;
      cand = IW'(idx);
      if (!hit && r[cand]) begin
        hit = 1'b1;
        res = cand;
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  assign pick = rr_pick(req, ptr);

  // Data word of the held winner; only used on the load edge.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IW'(i)) begin
        sel_d = din[i*W +: W];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = (req != '0) ? ST_GRANT : ST_IDLE;
      // A withdrawn request aborts straight back to IDLE.
      ST_GRANT: state_nxt = req[winner] ? ST_DONE : ST_IDLE;
      // DONE always returns to IDLE, which enforces the one-write-per-3-cycles gap.
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs (next values of the registered gnt/ack and the load strobe)
  always_comb begin
    gnt_nxt    = '0;
    ack_nxt    = '0;
    load       = 1'b0;
    winner_nxt = winner;
    case (state)
      ST_IDLE: begin
        if (req != '0) begin
          winner_nxt = pick;
          gnt_nxt    = onehot(pick);
        end
      end
      ST_GRANT: begin
        if (req[winner]) begin
          load    = 1'b1;
          ack_nxt = onehot(winner);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      ack    <= '0;
      winner <= '0;
      ptr    <= IW'(N - 1);
      q_src  <= '0;
    end else begin
      gnt    <= gnt_nxt;
      ack    <= ack_nxt;
      winner <= winner_nxt;
      if (load) begin
        ptr   <= winner;
        q_src <= winner;
      end
    end
  end

  dff_bank #(.W(W)) u_q_bank (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   (sel_d),
    .q   (q)
  );

`ifdef DFF_ARB_PARITY_EN
  logic par_d;
  assign par_d = ^sel_d;

  dff_bank #(.W(1)) u_par_bank (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   (par_d),
    .q   (q_par)
  );
`endif

  assign dbg_state = state;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
module tb_dff_reg_arbiter;
  import dff_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [IW-1:0]  q_src;
  logic [1:0]     dbg_state;
  logic           busy;
`ifdef DFF_ARB_PARITY_EN
  logic           q_par;
`endif

  int checks;
  int errors;

  dff_reg_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .ack       (ack),
    .q         (q),
    .q_src     (q_src),
    .dbg_state (dbg_state),
    .busy      (busy)
`ifdef DFF_ARB_PARITY_EN
    ,
    .q_par     (q_par)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [IW-1:0]  win;
    logic [W-1:0]   q;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, inputs also change there.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full write transaction: grant cycle, ack cycle, back to idle.
  task automatic run_txn(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] d,
                         input logic [IW-1:0] win, input logic [W-1:0] exp_q);
    logic [N-1:0] oh;
    oh  = 4'b0001 << win;
    req = r;
    din = d;
    step();
    check({tag, " gnt"}, 32'(gnt), 32'(oh));
    check({tag, " ack_in_grant"}, 32'(ack), 32'd0);
    check({tag, " state_grant"}, 32'(dbg_state), 32'(ST_GRANT));
    step();
    req = '0;
    check({tag, " q"}, 32'(q), 32'(exp_q));
    check({tag, " q_src"}, 32'(q_src), 32'(win));
    check({tag, " ack"}, 32'(ack), 32'(oh));
    check({tag, " gnt_clear"}, 32'(gnt), 32'd0);
`ifdef DFF_ARB_PARITY_EN
    check({tag, " q_par"}, 32'(q_par), 32'(^exp_q));
`endif
    step();
    check({tag, " ack_clear"}, 32'(ack), 32'd0);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
  endtask

  // gnt and ack must each be one-hot or zero and never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((gnt & (gnt - 1'b1)) != '0 || (ack & (ack - 1'b1)) != '0 || (gnt & ack) != '0) begin
        errors++;
        $display("FAIL onehot_invariant actual gnt=%b ack=%b required one-hot/zero, disjoint", gnt, ack);
      end
    end
  end

  initial begin
    vecs[0]  = '{4'b0100, 32'h11_A5_22_33, 2'd2, 8'hA5};
    vecs[1]  = '{4'b1111, 32'h44_33_22_11, 2'd3, 8'h44};
    vecs[2]  = '{4'b1111, 32'h48_37_26_15, 2'd0, 8'h15};
    vecs[3]  = '{4'b1111, 32'h48_37_26_15, 2'd1, 8'h26};
    vecs[4]  = '{4'b1111, 32'h48_37_26_15, 2'd2, 8'h37};
    vecs[5]  = '{4'b1111, 32'h48_37_26_15, 2'd3, 8'h48};
    vecs[6]  = '{4'b1111, 32'h00_00_00_07, 2'd0, 8'h07};
    vecs[7]  = '{4'b1010, 32'h00_00_03_00, 2'd1, 8'h03};
    vecs[8]  = '{4'b1001, 32'hC3_00_00_5A, 2'd3, 8'hC3};
    vecs[9]  = '{4'b0001, 32'h00_00_00_81, 2'd0, 8'h81};
    vecs[10] = '{4'b0111, 32'h00_F0_0F_FF, 2'd1, 8'h0F};
    vecs[11] = '{4'b1000, 32'h7E_00_00_00, 2'd3, 8'h7E};

    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = '0;
    din = '0;
    step();
    step();
    rst = 1'b0;
    check("reset q", 32'(q), 32'd0);
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset ack", 32'(ack), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset q_src", 32'(q_src), 32'd0);
`ifdef DFF_ARB_PARITY_EN
    check("reset q_par", 32'(q_par), 32'd0);
`endif
    step();
    check("idle no req", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].din, vecs[i].win, vecs[i].q);
    end

    // Withdraw during GRANT: no write, no ack, pointer untouched (still 3).
    req = 4'b0010;
    din = 32'h00_00_99_00;
    step();
    check("wd gnt", 32'(gnt), 32'b0010);
    req = '0;
    step();
    check("wd ack", 32'(ack), 32'd0);
    check("wd gnt_clear", 32'(gnt), 32'd0);
    check("wd q", 32'(q), 32'h7E);
    check("wd q_src", 32'(q_src), 32'd3);
    check("wd busy", 32'(busy), 32'd0);
    run_txn("wd_next", 4'b0011, 32'h00_00_BB_AA, 2'd0, 8'hAA);

    // Reset in the middle of GRANT: no partial write, pointer back to N-1.
    req = 4'b1000;
    din = 32'h3C_00_00_00;
    step();
    check("rstmid gnt", 32'(gnt), 32'b1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = '0;
    check("rstmid q", 32'(q), 32'd0);
    check("rstmid ack", 32'(ack), 32'd0);
    check("rstmid gnt", 32'(gnt), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid q_src", 32'(q_src), 32'd0);
    run_txn("post_rst0", 4'b1111, 32'h04_03_02_01, 2'd0, 8'h01);
    run_txn("post_rst1", 4'b1111, 32'h04_03_02_01, 2'd1, 8'h02);

    // Request held through DONE is deferred, not lost, and re-granted from IDLE.
    req = 4'b0100;
    din = 32'h00_5F_00_00;
    step();
    step();
    check("held ack", 32'(ack), 32'b0100);
    step();
    check("held idle_gap gnt", 32'(gnt), 32'd0);
    step();
    check("held regrant", 32'(gnt), 32'b0100);
    req = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
